// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the TDC start/stop pulse generator.
//   tdc_state_t      - controller FSM state encoding
//   *_DEF            - default widths and cycle counts used by tdc_pulse_gen
package tdc_pkg;

   localparam int unsigned CNT_W_DEF          = 32;
   localparam int unsigned FINE_W_DEF         = 9;
   localparam int unsigned REP_W_DEF          = 16;
   localparam int unsigned GAP_CYCLES_DEF     = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FIRE      = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_CAPTURE   = 3'd3,
      ST_GAP       = 3'd4
   } tdc_state_t;

endpackage

// File: rtl/tdc_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, output resets to 0
//   d      - asynchronous input level
//   q      - level synchronised to clk (two cycles of latency)
module tdc_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/tdc_pulse_gen.sv
// Start/stop stimulus generator and result collector for the on-chip TDC.
// Fires a start pulse and, a programmed number of cycles later, a stop
// pulse; waits for the TDC to drop busy, then captures its coarse/fine
// result as one valid-strobed record per shot, for cfg_repeat shots.
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   cfg_delay/pulse_len/repeat  - shot config, sampled on accepted go (0 -> 1)
//   go, abort                   - run request (IDLE only) / run cancel
//   start_signal, stop_signal   - registered TDC stimulus pulses
//   tdc_busy, tdc_coarse/fine   - TDC status (async) and measurement result
//   result_valid/coarse/fine/index - captured record, one strobe per shot
//   active, done, timeout_err   - run in progress / end-of-run strobe / sticky timeout
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for go
// ST_FIRE      | start/stop pulses in flight
// ST_WAIT_DONE | waiting for synchronised busy to fall, or the timeout
// ST_CAPTURE   | TDC result settled; registered into result_* on exit
// ST_GAP       | both pulses low for GAP_CYCLES before the next shot
module tdc_pulse_gen
   import tdc_pkg::*;
#(
   parameter int unsigned CNT_W          = CNT_W_DEF,
   parameter int unsigned FINE_W         = FINE_W_DEF,
   parameter int unsigned REP_W          = REP_W_DEF,
   parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  cfg_delay,
   input  logic [7:0]        cfg_pulse_len,
   input  logic [REP_W-1:0]  cfg_repeat,
   input  logic              go,
   input  logic              abort,
   output logic              start_signal,
   output logic              stop_signal,
   input  logic              tdc_busy,
   input  logic [CNT_W-1:0]  tdc_coarse,
   input  logic [FINE_W-1:0] tdc_fine,
   output logic              result_valid,
   output logic [CNT_W-1:0]  result_coarse,
   output logic [FINE_W-1:0] result_fine,
   output logic [REP_W-1:0]  result_index,
   output logic              active,
   output logic              done,
   output logic              timeout_err
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   tdc_state_t state, state_nxt;

   logic              busy_s;
   logic              busy_seen;
   logic [CNT_W-1:0]  delay_q, dly_cnt;
   logic [7:0]        plen_q, start_cnt, stop_cnt;
   logic [REP_W-1:0]  rep_q, shot_idx;
   logic [GAP_W-1:0]  gap_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              stop_fired;

   logic [CNT_W-1:0]  delay_in, delay_use;
   logic [7:0]        plen_in, plen_use;
   logic [REP_W-1:0]  rep_in;

   logic go_accept, shot_start, wait_enter, capture_en;
   logic run_end, tmo_hit, abort_hit, last_shot;

   tdc_sync2 u_busy_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tdc_busy),
      .q     (busy_s)
   );

   assign delay_in = (cfg_delay == '0)     ? CNT_W'(1) : cfg_delay;
   assign plen_in  = (cfg_pulse_len == '0) ? 8'd1      : cfg_pulse_len;
   assign rep_in   = (cfg_repeat == '0)    ? REP_W'(1) : cfg_repeat;

   // The first shot of a run loads its counters in the same edge that
   // latches the config, so it must see the live (clamped) inputs.
   assign delay_use = go_accept ? delay_in : delay_q;
   assign plen_use  = go_accept ? plen_in  : plen_q;

   assign last_shot = (shot_idx == rep_q - REP_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      go_accept  = 1'b0;
      shot_start = 1'b0;
      wait_enter = 1'b0;
      capture_en = 1'b0;
      run_end    = 1'b0;
      tmo_hit    = 1'b0;
      abort_hit  = 1'b0;

      if (state != ST_IDLE && abort) begin
         abort_hit = 1'b1;
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (go && !abort) begin
                  go_accept  = 1'b1;
                  shot_start = 1'b1;
                  state_nxt  = ST_FIRE;
               end
            end
            ST_FIRE: begin
               if (stop_signal && stop_cnt == 8'd0) begin
                  wait_enter = 1'b1;
                  state_nxt  = ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (busy_seen && !busy_s) begin
                  state_nxt = ST_CAPTURE;
               end else if (tmo_cnt == '0) begin
                  tmo_hit   = 1'b1;
                  run_end   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            ST_CAPTURE: begin
               capture_en = 1'b1;
               if (last_shot) begin
                  run_end   = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  shot_start = 1'b1;
                  state_nxt  = ST_FIRE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_signal  <= 1'b0;
         stop_signal   <= 1'b0;
         result_valid  <= 1'b0;
         result_coarse <= '0;
         result_fine   <= '0;
         result_index  <= '0;
         active        <= 1'b0;
         done          <= 1'b0;
         timeout_err   <= 1'b0;
         busy_seen     <= 1'b0;
         delay_q       <= '0;
         dly_cnt       <= '0;
         plen_q        <= '0;
         start_cnt     <= '0;
         stop_cnt      <= '0;
         rep_q         <= '0;
         shot_idx      <= '0;
         gap_cnt       <= '0;
         tmo_cnt       <= '0;
         stop_fired    <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         done         <= 1'b0;

         if (go_accept) begin
            delay_q     <= delay_in;
            plen_q      <= plen_in;
            rep_q       <= rep_in;
            shot_idx    <= '0;
            timeout_err <= 1'b0;
            active      <= 1'b1;
         end

         // Counters hold "remaining cycles after this one", so a terminal
         // count of zero marks the last cycle; the delay counter stops at
         // zero, which keeps a full-scale delay from wrapping.
         if (shot_start) begin
            start_signal <= 1'b1;
            stop_signal  <= 1'b0;
            stop_fired   <= 1'b0;
            busy_seen    <= 1'b0;
            start_cnt    <= plen_use - 8'd1;
            dly_cnt      <= delay_use - CNT_W'(1);
         end else if (state == ST_FIRE) begin
            if (start_signal) begin
               if (start_cnt == 8'd0) begin
                  start_signal <= 1'b0;
               end else begin
                  start_cnt <= start_cnt - 8'd1;
               end
            end
            if (!stop_fired) begin
               if (dly_cnt == '0) begin
                  stop_signal <= 1'b1;
                  stop_fired  <= 1'b1;
                  stop_cnt    <= plen_q - 8'd1;
               end else begin
                  dly_cnt <= dly_cnt - CNT_W'(1);
               end
            end else if (stop_signal) begin
               if (stop_cnt == 8'd0) begin
                  stop_signal <= 1'b0;
               end else begin
                  stop_cnt <= stop_cnt - 8'd1;
               end
            end
         end

         // A TDC that never raised busy cannot be waited on; only the
         // timeout ends such a shot.
         if ((state == ST_FIRE || state == ST_WAIT_DONE) && busy_s) begin
            busy_seen <= 1'b1;
         end

         if (wait_enter) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
         end else if (state == ST_WAIT_DONE && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
         end

         if (capture_en) begin
            result_coarse <= tdc_coarse;
            result_fine   <= tdc_fine;
            result_index  <= shot_idx;
            result_valid  <= 1'b1;
            gap_cnt       <= GAP_W'(GAP_CYCLES - 1);
            if (!last_shot) begin
               shot_idx <= shot_idx + REP_W'(1);
            end
         end else if (state == ST_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end

         if (tmo_hit) begin
            timeout_err <= 1'b1;
         end

         if (run_end) begin
            done   <= 1'b1;
            active <= 1'b0;
         end

         if (abort_hit) begin
            start_signal <= 1'b0;
            stop_signal  <= 1'b0;
            active       <= 1'b0;
            done         <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
module tb_tdc_pulse_gen;

   localparam int CNT_W          = 32;
   localparam int FINE_W         = 9;
   localparam int REP_W          = 16;
   localparam int GAP_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 1024;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [CNT_W-1:0]  cfg_delay = '0;
   logic [7:0]        cfg_pulse_len = '0;
   logic [REP_W-1:0]  cfg_repeat = '0;
   logic              go = 1'b0;
   logic              abort = 1'b0;
   logic              start_signal, stop_signal;
   logic              tdc_busy = 1'b0;
   logic [CNT_W-1:0]  tdc_coarse = '0;
   logic [FINE_W-1:0] tdc_fine = '0;
   logic              result_valid;
   logic [CNT_W-1:0]  result_coarse;
   logic [FINE_W-1:0] result_fine;
   logic [REP_W-1:0]  result_index;
   logic              active, done, timeout_err;

   tdc_pulse_gen #(
      .CNT_W          (CNT_W),
      .FINE_W         (FINE_W),
      .REP_W          (REP_W),
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_delay     (cfg_delay),
      .cfg_pulse_len (cfg_pulse_len),
      .cfg_repeat    (cfg_repeat),
      .go            (go),
      .abort         (abort),
      .start_signal  (start_signal),
      .stop_signal   (stop_signal),
      .tdc_busy      (tdc_busy),
      .tdc_coarse    (tdc_coarse),
      .tdc_fine      (tdc_fine),
      .result_valid  (result_valid),
      .result_coarse (result_coarse),
      .result_fine   (result_fine),
      .result_index  (result_index),
      .active        (active),
      .done          (done),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int delay;
      int plen;
      int gap;
      int overlap;
   } pulse_exp_t;

   typedef struct {
      bit     is_result;
      longint coarse;
      longint fine;
      longint index;
      bit     done_also;
      bit     tmo;
      int     tmo_lat;
   } evt_exp_t;

   pulse_exp_t pulse_q[$];
   evt_exp_t   evt_q[$];
   pulse_exp_t pe;
   evt_exp_t   ev;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   task automatic push_pulse(input int d, input int p, input int g, input int o);
      pulse_exp_t x;
      x.delay = d; x.plen = p; x.gap = g; x.overlap = o;
      pulse_q.push_back(x);
   endtask

   task automatic push_res(input longint c, input longint f, input longint i, input bit dn);
      evt_exp_t x;
      x.is_result = 1'b1; x.coarse = c; x.fine = f; x.index = i;
      x.done_also = dn; x.tmo = 1'b0; x.tmo_lat = -1;
      evt_q.push_back(x);
   endtask

   task automatic push_done(input bit tmo, input int lat);
      evt_exp_t x;
      x.is_result = 1'b0; x.coarse = 0; x.fine = 0; x.index = 0;
      x.done_also = 1'b1; x.tmo = tmo; x.tmo_lat = lat;
      evt_q.push_back(x);
   endtask

   // TDC model: busy on start rise, busy drops 20 cycles after stop rise
   // with coarse/fine = base + shot number of this run.
   bit   tdc_en = 1'b0;
   int   coarse_base = 0, fine_base = 0;
   int   tdc_cnt = 0, model_shot = 0;
   logic m_prev_start = 1'b0, m_prev_stop = 1'b0;

   always @(negedge clk) begin
      if (!tdc_en) begin
         tdc_busy   = 1'b0;
         tdc_cnt    = 0;
         model_shot = 0;
      end else begin
         if (start_signal && !m_prev_start) tdc_busy = 1'b1;
         if (stop_signal && !m_prev_stop) begin
            tdc_cnt = 20;
         end else if (tdc_cnt > 0) begin
            tdc_cnt--;
            if (tdc_cnt == 0) begin
               tdc_busy   = 1'b0;
               tdc_coarse = CNT_W'(coarse_base + model_shot);
               tdc_fine   = FINE_W'(fine_base + model_shot);
               model_shot++;
            end
         end
      end
      m_prev_start = start_signal;
      m_prev_stop  = stop_signal;
   end

   // Monitor: pulse timing and the result/done scoreboard.
   int   cyc = 0;
   logic prev_start = 1'b0, prev_stop = 1'b0;
   int   start_rise = 0, stop_rise = 0, start_w = 0, stop_w = 0, ovl = 0;
   int   last_rv = -1000, last_stop_fall = 0;
   int   start_rises = 0, stop_rises = 0;

   always @(negedge clk) begin
      cyc++;
      if (start_signal && !prev_start) begin
         start_rise = cyc; start_w = 0; ovl = 0; start_rises++;
      end
      if (stop_signal && !prev_stop) begin
         stop_rise = cyc; stop_w = 0; stop_rises++;
      end
      if (start_signal) start_w++;
      if (stop_signal) stop_w++;
      if (start_signal && stop_signal) ovl++;

      if (prev_stop && !stop_signal) begin
         last_stop_fall = cyc;
         if (pulse_q.size() == 0) begin
            fail("unexpected_shot");
         end else begin
            pe = pulse_q.pop_front();
            chk("stop_separation", stop_rise - start_rise, pe.delay);
            chk("start_width", start_w, pe.plen);
            chk("stop_width", stop_w, pe.plen);
            chk("overlap", ovl, pe.overlap);
            if (pe.gap >= 0) chk("gap_before_start", start_rise - last_rv, pe.gap);
         end
      end

      if (result_valid) begin
         last_rv = cyc;
         if (evt_q.size() == 0) begin
            fail("unexpected_result_valid");
         end else begin
            ev = evt_q.pop_front();
            chk("event_is_result", 1, ev.is_result);
            chk("result_coarse", result_coarse, ev.coarse);
            chk("result_fine", result_fine, ev.fine);
            chk("result_index", result_index, ev.index);
            chk("done_with_result", done, ev.done_also);
         end
      end else if (done) begin
         if (evt_q.size() == 0) begin
            fail("unexpected_done");
         end else begin
            ev = evt_q.pop_front();
            chk("event_is_done_only", 0, ev.is_result);
            chk("timeout_err_at_done", timeout_err, ev.tmo);
            if (ev.tmo_lat >= 0) chk("timeout_latency", cyc - last_stop_fall, ev.tmo_lat);
         end
      end

      prev_start = start_signal;
      prev_stop  = stop_signal;
   end

   task automatic model_setup(input int cb, input int fb);
      tdc_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      coarse_base = cb;
      fine_base   = fb;
      tdc_en      = 1'b1;
   endtask

   task automatic run_go(input int d, input int p, input int r);
      cfg_delay     = CNT_W'(d);
      cfg_pulse_len = 8'(p);
      cfg_repeat    = REP_W'(r);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) fail({name, "_done_timeout"});
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sr, st;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {start_signal, stop_signal, result_valid, result_coarse, result_fine,
                            result_index, active, done, timeout_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single shot, delay 10, pulse 2
      model_setup(10, 37);
      push_pulse(10, 2, -1, 0);
      push_res(10, 37, 0, 1'b1);
      run_go(10, 2, 1);
      chk("active_after_go", active, 1);
      chk("start_first_fire_cycle", start_signal, 1);
      wait_done(300, "single");
      chk("active_after_done", active, 0);

      // overlapping pulses
      model_setup(50, 60);
      push_pulse(1, 4, -1, 3);
      push_res(50, 60, 0, 1'b1);
      run_go(1, 4, 1);
      wait_done(300, "overlap");

      // three shots with gaps
      model_setup(100, 200);
      push_pulse(5, 3, -1, 0);
      push_pulse(5, 3, GAP_CYCLES, 0);
      push_pulse(5, 3, GAP_CYCLES, 0);
      push_res(100, 200, 0, 1'b0);
      push_res(101, 201, 1, 1'b0);
      push_res(102, 202, 2, 1'b1);
      run_go(5, 3, 3);
      wait_done(600, "repeat");

      // busy never rises: timeout
      tdc_en = 1'b0;
      repeat (2) @(negedge clk);
      push_pulse(3, 1, -1, 0);
      push_done(1'b1, TIMEOUT_CYCLES);
      run_go(3, 1, 1);
      wait_done(TIMEOUT_CYCLES + 200, "timeout");
      repeat (3) @(negedge clk);
      chk("timeout_err_sticky", timeout_err, 1);

      // next go clears timeout_err
      model_setup(70, 80);
      push_pulse(4, 2, -1, 0);
      push_res(70, 80, 0, 1'b1);
      run_go(4, 2, 1);
      chk("timeout_err_cleared", timeout_err, 0);
      wait_done(300, "after_timeout");

      // abort 3 cycles after the start rise
      model_setup(0, 0);
      push_done(1'b0, -1);
      sr = stop_rises;
      run_go(10, 2, 1);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_start_low", start_signal, 0);
      chk("abort_active_low", active, 0);
      chk("abort_done", done, 1);
      repeat (12) @(negedge clk);
      chk("abort_no_stop", stop_rises - sr, 0);
      chk("abort_no_timeout_err", timeout_err, 0);

      // go with abort in IDLE is ignored
      tdc_en = 1'b0;
      st = start_rises;
      cfg_delay = 2; cfg_pulse_len = 1; cfg_repeat = 1;
      go = 1'b1; abort = 1'b1;
      @(negedge clk);
      go = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("go_abort_active", active, 0);
      chk("go_abort_no_start", start_rises - st, 0);

      // asynchronous reset mid-FIRE, then a normal shot
      model_setup(0, 0);
      run_go(10, 5, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {start_signal, stop_signal, result_valid, result_coarse,
                                     result_fine, result_index, active, done, timeout_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_setup(300, 301);
      push_pulse(2, 2, -1, 0);
      push_res(300, 301, 0, 1'b1);
      run_go(2, 2, 1);
      chk("active_after_reset_go", active, 1);
      wait_done(300, "after_reset");

      // zero config clamps to 1
      model_setup(5, 6);
      push_pulse(1, 1, -1, 0);
      push_res(5, 6, 0, 1'b1);
      run_go(0, 0, 0);
      wait_done(300, "clamp");

      repeat (5) @(negedge clk);
      chk("pulse_queue_drained", pulse_q.size(), 0);
      chk("event_queue_drained", evt_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
